// File: rtl/mannix_mem_read_client.sv
// Memory-farm read client: splits a byte-range job into line-sized read
// requests, one outstanding at a time. Returned lines are buffered in a
// two-entry first-word-fall-through FIFO for the consumer. A watchdog
// aborts the job if the memory farm stops answering.
module mannix_mem_read_client #(
   parameter int ADDR_WIDTH = 19,
   parameter int LINE_BYTES = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  total_bytes,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_start_addr,
   output logic [4:0]            mem_size_bytes,
   input  logic                  mem_valid,
   input  logic [255:0]          mem_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [255:0]          out_data,
   output logic [5:0]            out_bytes,
   output logic                  out_last
);

   localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      ERR   = 2'd3
   } state_t;

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [LEN_WIDTH-1:0]  remaining_reg;
   logic [WD_WIDTH-1:0]   wd_cnt_reg;

   // Output FIFO storage and control
   logic [255:0] fifo_data_reg  [2];
   logic [5:0]   fifo_bytes_reg [2];
   logic         fifo_last_reg  [2];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   logic [1:0]   count_reg;

   logic [5:0] chunk;
   logic       chunk_last;
   logic       accept;
   logic       pop;
   logic       wd_fire;
   logic       fifo_empty;
   logic       fifo_full;

   // Size of the next line request: whole line, or whatever is left
   always_comb begin
      chunk = 6'(LINE_BYTES);
      if (remaining_reg < LEN_WIDTH'(LINE_BYTES)) begin
         chunk = remaining_reg[5:0];
      end
   end

   assign chunk_last = (remaining_reg == LEN_WIDTH'(chunk));
   // A response only counts while our request is up; stray mem_valid is ignored
   assign accept     = mem_req && mem_valid;
   assign fifo_empty = (count_reg == 2'd0);
   assign fifo_full  = (count_reg == 2'd2);
   assign pop        = !fifo_empty && out_ready;
   // Watchdog fires on the cycle that would make TIMEOUT cycles of unanswered request
   assign wd_fire    = mem_req && !mem_valid && (wd_cnt_reg == WD_WIDTH'(TIMEOUT - 1));

   // Consumer view of the FIFO head; quiet zeros when empty
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0    : fifo_data_reg[rd_ptr_reg];
   assign out_bytes = fifo_empty ? 6'd0  : fifo_bytes_reg[rd_ptr_reg];
   assign out_last  = fifo_empty ? 1'b0  : fifo_last_reg[rd_ptr_reg];

   // FIFO entry storage: each slot captures the returned line when it is the write target
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (!rst && !wd_fire && accept && (wr_ptr_reg == 1'(gi))) begin
               fifo_data_reg[gi]  <= mem_data;
               fifo_bytes_reg[gi] <= chunk;
               fifo_last_reg[gi]  <= chunk_last;
            end
         end
      end
   endgenerate

   // FIFO pointers and occupancy; a watchdog abort discards everything buffered
   always_ff @(posedge clk) begin
      if (rst || wd_fire) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (accept) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         case ({accept, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Job sequencer: request issue, address/length bookkeeping, watchdog and status
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         remaining_reg  <= '0;
         wd_cnt_reg     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         timeout_err    <= 1'b0;
         mem_req        <= 1'b0;
         mem_start_addr <= '0;
         mem_size_bytes <= 5'd0;
      end else begin
         done <= 1'b0;

         // Count only cycles spent waiting on an unanswered request
         if (mem_req && !accept) begin
            wd_cnt_reg <= wd_cnt_reg + WD_WIDTH'(1);
         end else begin
            wd_cnt_reg <= '0;
         end

         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (total_bytes != '0) begin
                     addr_reg      <= start_addr;
                     remaining_reg <= total_bytes;
                     busy          <= 1'b1;
                     state_reg     <= REQ;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end

            REQ: begin
               if (mem_req) begin
                  if (accept) begin
                     mem_req       <= 1'b0;
                     addr_reg      <= addr_reg + ADDR_WIDTH'(chunk);
                     remaining_reg <= remaining_reg - LEN_WIDTH'(chunk);
                     if (chunk_last) begin
                        state_reg <= DRAIN;
                     end
                  end else if (wd_fire) begin
                     mem_req     <= 1'b0;
                     timeout_err <= 1'b1;
                     state_reg   <= ERR;
                  end
               end else if (!fifo_full) begin
                  // Address and size are frozen here until the line comes back
                  mem_req        <= 1'b1;
                  mem_start_addr <= addr_reg;
                  mem_size_bytes <= 5'(chunk - 6'd1);
               end
            end

            DRAIN: begin
               if (pop && (count_reg == 2'd1)) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end

            default: begin
               // ERR: parked with busy held until reset
               busy <= 1'b1;
            end
         endcase
      end
   end

endmodule
